ex_stage: RTL and testbench

//  Execute stage. Consumes the registered id_ex_* bundle, computes the ALU result and drives forward_data back to decode.

---
 rtl/ex_stage_pkg.sv | 43 ++++
 rtl/ex_stage_muldiv_unit.sv | 90 +++++++++
 rtl/ex_stage.sv | 111 +++++++++++
 tb/tb_ex_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply/divide FSM states,
// the ex_mem register bundle and the default iteration count.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_LUI  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_REMU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic        write_register;
    logic [4:0]  register_number;
    logic [1:0]  register_source;
    logic        write_data;
    logic [31:0] alu_result;
    logic [31:0] data;
  } ex_mem_t;

  localparam int MD_CYCLES_DEFAULT = 32;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Only built when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_unit
  import ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result
);

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [3:0]    op_q, op_d;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for divides.
  logic [32:0] mul_sum, rem_ext, div_diff;
  logic        div_ge;
  logic [63:0] mul_step, div_step;

  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_step = {mul_sum, acc_q[31:1]};
  assign rem_ext  = acc_q[63:31];
  assign div_ge   = rem_ext >= {1'b0, opnd_q};
  assign div_diff = rem_ext - {1'b0, opnd_q};
  assign div_step = {(div_ge ? div_diff[31:0] : rem_ext[31:0]), acc_q[30:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    done    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d    = op;
          opnd_d  = (op == ALU_MUL) ? a : b;
          acc_d   = {32'd0, ((op == ALU_MUL) ? b : a)};
          cnt_d   = '0;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        acc_d = (op_q == ALU_MUL) ? mul_step : div_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = MD_DONE;
      end
      MD_DONE: begin
        done    = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign result = (op_q == ALU_REMU) ? acc_q[63:32] : acc_q[31:0];

  // NOTE: datapath registers are reset as well so the result is deterministic after resetn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, forward mux to decode and the ex_mem register bank.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit and its stall.
module ex_stage
  import ex_stage_pkg::*;
`ifdef EX_MULDIV_EN
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
)
`endif
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  id_ex_alu_operation,
  input  logic [31:0] id_ex_alu_parameter1,
  input  logic [31:0] id_ex_alu_parameter2,
  input  logic        id_ex_write_register,
  input  logic [4:0]  id_ex_register_number,
  input  logic [1:0]  id_ex_register_source,
  input  logic        id_ex_write_data,
  input  logic [31:0] id_ex_data,
  input  logic [31:0] id_ex_pc4,
  output logic [31:0] forward_data,
  output logic        busy,
  output logic        ex_mem_write_register,
  output logic [4:0]  ex_mem_register_number,
  output logic [1:0]  ex_mem_register_source,
  output logic        ex_mem_write_data,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_data
);

  logic [31:0] op_a, op_b, alu_result, exe_result;
  logic [4:0]  sh;
  ex_mem_t     ex_mem_q, ex_mem_d;

  assign op_a = id_ex_alu_parameter1;
  assign op_b = id_ex_alu_parameter2;
  assign sh   = op_a[4:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(id_ex_alu_operation))
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_NOR: alu_result = ~(op_a | op_b);
      ALU_LUI: alu_result = {op_b[15:0], 16'h0000};
      ALU_SLT: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_result = op_b << sh;
      ALU_SRL: alu_result = op_b >> sh;
      ALU_SRA: alu_result = $signed(op_b) >>> sh;
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic        md_op, md_done;
  logic [31:0] md_result;

  assign md_op = is_muldiv(id_ex_alu_operation);

  muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clock  (clock),
    .resetn (resetn),
    .start  (md_op),
    .op     (id_ex_alu_operation),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  // Gated by resetn so the stall drops the moment an operation is aborted.
  assign busy       = resetn & md_op & ~md_done;
  assign exe_result = md_op ? md_result : alu_result;
`else
  assign busy       = 1'b0;
  assign exe_result = alu_result;
`endif

  assign forward_data = id_ex_register_source[0] ? id_ex_pc4 : exe_result;

  always_comb begin
    ex_mem_d = '0;
    if (!busy) begin
      ex_mem_d.write_register  = id_ex_write_register;
      ex_mem_d.register_number = id_ex_register_number;
      ex_mem_d.register_source = id_ex_register_source;
      ex_mem_d.write_data      = id_ex_write_data;
      ex_mem_d.alu_result      = forward_data;
      ex_mem_d.data            = id_ex_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ex_mem_q <= '0;
    else         ex_mem_q <= ex_mem_d;
  end

  assign ex_mem_write_register  = ex_mem_q.write_register;
  assign ex_mem_register_number = ex_mem_q.register_number;
  assign ex_mem_register_source = ex_mem_q.register_source;
  assign ex_mem_write_data      = ex_mem_q.write_data;
  assign ex_mem_alu_result      = ex_mem_q.alu_result;
  assign ex_mem_data            = ex_mem_q.data;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes expected ex_mem contents, a negedge
// monitor pops and compares whenever ex_mem_write_register is set.
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_STALL = MD_EN ? (MD_CYCLES_DEFAULT + 1) : 0;

  logic        clock, resetn;
  logic [3:0]  id_ex_alu_operation;
  logic [31:0] id_ex_alu_parameter1, id_ex_alu_parameter2;
  logic        id_ex_write_register;
  logic [4:0]  id_ex_register_number;
  logic [1:0]  id_ex_register_source;
  logic        id_ex_write_data;
  logic [31:0] id_ex_data, id_ex_pc4;
  logic [31:0] forward_data;
  logic        busy;
  logic        ex_mem_write_register;
  logic [4:0]  ex_mem_register_number;
  logic [1:0]  ex_mem_register_source;
  logic        ex_mem_write_data;
  logic [31:0] ex_mem_alu_result, ex_mem_data;

  ex_stage dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .id_ex_alu_operation    (id_ex_alu_operation),
    .id_ex_alu_parameter1   (id_ex_alu_parameter1),
    .id_ex_alu_parameter2   (id_ex_alu_parameter2),
    .id_ex_write_register   (id_ex_write_register),
    .id_ex_register_number  (id_ex_register_number),
    .id_ex_register_source  (id_ex_register_source),
    .id_ex_write_data       (id_ex_write_data),
    .id_ex_data             (id_ex_data),
    .id_ex_pc4              (id_ex_pc4),
    .forward_data           (forward_data),
    .busy                   (busy),
    .ex_mem_write_register  (ex_mem_write_register),
    .ex_mem_register_number (ex_mem_register_number),
    .ex_mem_register_source (ex_mem_register_source),
    .ex_mem_write_data      (ex_mem_write_data),
    .ex_mem_alu_result      (ex_mem_alu_result),
    .ex_mem_data            (ex_mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rn;
    logic [1:0]  src;
    logic        wd;
    logic [31:0] res;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rn, input logic [1:0] src, input logic wd,
                       input logic [31:0] data, input logic [31:0] pc4);
    id_ex_alu_operation   = op;
    id_ex_alu_parameter1  = a;
    id_ex_alu_parameter2  = b;
    id_ex_write_register  = 1'b1;
    id_ex_register_number = rn;
    id_ex_register_source = src;
    id_ex_write_data      = wd;
    id_ex_data            = data;
    id_ex_pc4             = pc4;
  endtask

  // Called just after a rising edge; returns just after the edge that captures the op.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rn, input logic [1:0] src,
                       input logic wd, input logic [31:0] data, input logic [31:0] pc4,
                       input logic [31:0] exp_fwd, input int exp_stall);
    int n;
    exp_t e;
    drive(op, a, b, rn, src, wd, data, pc4);
    e = '{rn: rn, src: src, wd: wd, res: exp_fwd, data: data};
    sb.push_back(e);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clock);
      #1;
    end
    check({name, "_stall"}, 32'(n), 32'(exp_stall));
    check({name, "_fwd"}, forward_data, exp_fwd);
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (prev_busy) check("bubble_wr", 32'(ex_mem_write_register), 32'd0);
      if (ex_mem_write_register === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_capture: got rn=%0d with empty scoreboard", ex_mem_register_number);
        end else begin
          e = sb.pop_front();
          check("mem_rn",   32'(ex_mem_register_number), 32'(e.rn));
          check("mem_src",  32'(ex_mem_register_source), 32'(e.src));
          check("mem_wd",   32'(ex_mem_write_data), 32'(e.wd));
          check("mem_res",  ex_mem_alu_result, e.res);
          check("mem_data", ex_mem_data, e.data);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : driver
    resetn = 1'b0;
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 32'd0, 32'd0);
    id_ex_write_register = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_wr",   32'(ex_mem_write_register), 32'd0);
    check("rst_res",  ex_mem_alu_result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;

    issue("add",    ALU_ADD, 32'd5, 32'd7, 5'd8, 2'b00, 1'b0, 32'd0, 32'd0, 32'd12, 0);
    issue("jal",    ALU_ADD, 32'd1, 32'd1, 5'd31, 2'b01, 1'b0, 32'd0, 32'h0040_0008, 32'h0040_0008, 0);
    issue("sub",    ALU_SUB, 32'd3, 32'd5, 5'd1, 2'b00, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 0);
    issue("and",    ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd2, 2'b00, 1'b0, 32'd0, 32'd0, 32'h00F0_000F, 0);
    issue("or",     ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd3, 2'b00, 1'b0, 32'd0, 32'd0, 32'hFFF0_0FFF, 0);
    issue("xor",    ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd4, 2'b00, 1'b0, 32'd0, 32'd0, 32'hFF00_0FF0, 0);
    issue("nor",    ALU_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd5, 2'b00, 1'b0, 32'd0, 32'd0, 32'h000F_F000, 0);
    issue("lui",    ALU_LUI, 32'd0, 32'h0000_1234, 5'd6, 2'b00, 1'b0, 32'd0, 32'd0, 32'h1234_0000, 0);
    issue("slt_t",  ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd7, 2'b00, 1'b0, 32'd0, 32'd0, 32'd1, 0);
    issue("slt_f",  ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd7, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 0);
    issue("sll",    ALU_SLL, 32'd4, 32'h8000_0001, 5'd9, 2'b00, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 0);
    issue("srl",    ALU_SRL, 32'd4, 32'h8000_0010, 5'd10, 2'b00, 1'b0, 32'd0, 32'd0, 32'h0800_0001, 0);
    issue("sra",    ALU_SRA, 32'd4, 32'h8000_0010, 5'd11, 2'b00, 1'b0, 32'd0, 32'd0, 32'hF800_0001, 0);
    issue("wrap",   ALU_ADD, 32'hFFFF_FFFF, 32'd2, 5'd12, 2'b00, 1'b0, 32'd0, 32'd0, 32'd1, 0);
    issue("rsvd",   4'd14,   32'd5, 32'd7, 5'd13, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 0);
    issue("store",  ALU_ADD, 32'h1000, 32'h10, 5'd0, 2'b00, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h0000_1010, 0);

    issue("mul",    ALU_MUL,  32'd6, 32'd7, 5'd14, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'd42 : 32'd0, MD_STALL);
    issue("mul_ff", ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'd1 : 32'd0, MD_STALL);
    issue("divu",   ALU_DIVU, 32'd100, 32'd7, 5'd16, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'd14 : 32'd0, MD_STALL);
    issue("remu",   ALU_REMU, 32'd100, 32'd7, 5'd17, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'd2 : 32'd0, MD_STALL);
    issue("divu0",  ALU_DIVU, 32'd9, 32'd0, 5'd18, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'hFFFF_FFFF : 32'd0, MD_STALL);
    issue("remu0",  ALU_REMU, 32'd9, 32'd0, 5'd19, 2'b00, 1'b0, 32'd0, 32'd0, MD_EN ? 32'd9 : 32'd0, MD_STALL);

`ifdef EX_MULDIV_EN
    // Abort a multiply at cnt=10, then confirm a plain ADD runs without stalling.
    drive(ALU_MUL, 32'd6, 32'd7, 5'd20, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    repeat (11) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr",   32'(ex_mem_write_register), 32'd0);
    check("abort_rn",   32'(ex_mem_register_number), 32'd0);
    check("abort_res",  ex_mem_alu_result, 32'd0);
    @(posedge clock);
    #1;
    drive(ALU_ADD, 32'd1, 32'd1, 5'd21, 2'b00, 1'b0, 32'd0, 32'd0);
    resetn = 1'b1;
    issue("post_abort", ALU_ADD, 32'd1, 32'd1, 5'd21, 2'b00, 1'b0, 32'd0, 32'd0, 32'd2, 0);
`endif

    issue("last",   ALU_ADD, 32'd3, 32'd4, 5'd22, 2'b00, 1'b0, 32'd0, 32'd0, 32'd7, 0);
    id_ex_write_register = 1'b0;
    id_ex_write_data     = 1'b0;
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("areset_wr",  32'(ex_mem_write_register), 32'd0);
    check("areset_res", ex_mem_alu_result, 32'd0);
    @(negedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
